demux_1_to_16_reg: RTL
======================

Name: demux_1_to_16_reg

Overview:
- Registered 1-to-16 demultiplexer: the distribution end of the 16-to-1 byte selection path in lab7.
- Accepts one 8-bit word per handshake from a single source and steers it to one of 16 channel holding registers.
- Each channel presents valid/ack to its own consumer.
- Destination is either the explicit select or an internal round-robin pointer.

Parameters:
- WIDTH, 8, data width of every channel.
- CHANNELS, 16, number of output channels; fixed at 16, select is 4 bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  source offers data_in.
- in_ready  output  1  block accepts data_in this cycle.
- data_in  input  WIDTH  word to distribute.
- sel  input  4  destination channel when auto_inc=0.
- auto_inc  input  1  1: destination is the internal pointer; sel is ignored.
- q  output  CHANNELS*WIDTH  flattened holding registers; channel k occupies bits [k*WIDTH +: WIDTH].
- q_valid  output  CHANNELS  per-channel data-present flag.
- q_ack  input  CHANNELS  per-channel consumer acknowledge.
- ptr  output  4  current round-robin pointer.
- overrun_cnt  output  8  overwrite count; tied to 0 unless DEMUX_OVERWRITE_EN is defined.

Behaviour:
- Reset (rst_n=0, asynchronous): q=0, q_valid=0, ptr=0, overrun_cnt=0. Reset asserted mid-transfer discards all held data; the first accept after deassertion lands in channel 0 when auto_inc=1.
- dest = auto_inc ? ptr : sel, combinational.
- in_ready = !q_valid[dest] || q_ack[dest], combinational. Depends only on registered state and current inputs, never on in_valid.
- Accept = in_valid && in_ready. On accept:
  - q[dest] <= data_in.
  - q_valid[dest] <= 1.
  - If auto_inc=1: ptr <= ptr+1, wrapping 15->0.
- Latency: data and valid are visible at the outputs one cycle after the accept edge.
- Consumer side: q_ack[k] && q_valid[k] clears q_valid[k] at the edge. q_ack on a non-valid channel is ignored. q[k] keeps its last value after it is consumed.
- Simultaneous ack and accept on the same channel: the new word is loaded and q_valid stays 1, giving one transfer per cycle on that channel.
- Ack on channel j and accept on channel k≠j in the same cycle: both take effect independently.
- ptr advances only on an accept with auto_inc=1. It does not move while blocked (in_ready=0) or while auto_inc=0.
- Toggling auto_inc never resets ptr.
- No internal FSM beyond per-channel valid flags and the pointer. There is no bypass path: data_in never reaches q combinationally.

Optional Feature:
- Macro: DEMUX_OVERWRITE_EN.
- Defined:
  - in_ready is constantly 1.
  - An accept into a channel with q_valid=1 and no q_ack that cycle overwrites the held word.
  - That event increments overrun_cnt, saturating at 255. Simultaneous ack on that channel is not an overrun.
  - overrun_cnt clears only on reset.
- Undefined: backpressure behaviour as above; overrun_cnt is constant 0.

Decomposition:
- Package demux_pkg:
  - constants WIDTH=8, CHANNELS=16, SEL_W=4;
  - typedef chan_idx_t (4-bit channel index);
  - typedef word_t (WIDTH-bit).
- Sub-module demux_slot, instantiated 16 times. Per instance it holds:
  - the holding register and valid flag;
  - load/ack inputs, with load-wins-with-valid-kept precedence;
  - an overrun pulse output, used only under the macro.
- The top level contains dest selection, in_ready, the pointer and the counter.

Test Plan:
- Reset, then auto_inc=0, sel=5, data_in=0xA5, in_valid=1 for one cycle -> next cycle q[47:40]=0xA5, q_valid=0x0020; all other channels 0.
- With channel 5 valid and no ack, offer sel=5, data 0x3C -> in_ready=0 and q[5] stays 0xA5. Assert q_ack[5] in the same cycle -> accept, q[5]=0x3C, q_valid[5] stays 1.
- auto_inc=1, 17 back-to-back accepts of 0x00..0x10 with each channel acked one cycle after it becomes valid -> channels 0..15 receive 0x00..0x0F. The 17th word 0x10 lands in channel 0, ptr wraps 15->0->1.
- auto_inc=1 with ptr's channel full and unacked for 3 cycles -> ptr and q are unchanged, in_ready=0; after the ack, resumes at the same ptr.
- Load channels 2 and 9, then pulse rst_n=0 asynchronously between edges -> q_valid=0, q=0 and ptr=0 immediately, before the next clock edge.
- DEMUX_OVERWRITE_EN: write channel 3 four times with no ack -> in_ready=1 throughout, q[3]=last word, overrun_cnt=3. The same sequence with a concurrent ack on the second write gives overrun_cnt=2.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-16 demultiplexer.
// The same package is used by the build with or without DEMUX_OVERWRITE_EN.
package demux_pkg;
   localparam int WIDTH    = 8;
   localparam int CHANNELS = 16;
   localparam int SEL_W    = 4;

   typedef logic [SEL_W-1:0] chan_idx_t;
   typedef logic [WIDTH-1:0] word_t;

   localparam logic [7:0] OVERRUN_MAX = 8'hFF;
endpackage

// File: rtl/demux_slot.sv
// One channel holding register plus its valid flag.
// DEMUX_OVERWRITE_EN: when defined, the overrun output flags a load into an occupied, unacked slot.
module demux_slot
   import demux_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  load,
   input  logic  ack,
   input  word_t data,
   output word_t q,
   output logic  valid,
   output logic  overrun
);

   // A load in the same cycle as an ack wins and keeps valid set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q     <= '0;
         valid <= 1'b0;
      end else if (load) begin
         q     <= data;
         valid <= 1'b1;
      end else if (ack && valid) begin
         valid <= 1'b0;
      end
   end

`ifdef DEMUX_OVERWRITE_EN
   assign overrun = load && valid && !ack;
`else
   assign overrun = 1'b0;
`endif

endmodule

// File: rtl/demux_1_to_16_reg.sv
// Registered 1-to-16 demultiplexer: explicit or round-robin destination, per-channel valid/ack.
// DEMUX_OVERWRITE_EN: when defined, in_ready is always 1 and overwrites are counted in overrun_cnt.
module demux_1_to_16_reg
   import demux_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          data_in,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      auto_inc,
   output logic [CHANNELS*WIDTH-1:0] q,
   output logic [CHANNELS-1:0]       q_valid,
   input  logic [CHANNELS-1:0]       q_ack,
   output logic [SEL_W-1:0]          ptr,
   output logic [7:0]                overrun_cnt
);

   chan_idx_t           dest;
   logic                accept;
   logic [CHANNELS-1:0] load;
   logic [CHANNELS-1:0] overrun;

   assign dest = auto_inc ? ptr : sel;

`ifdef DEMUX_OVERWRITE_EN
   assign in_ready = 1'b1;
`else
   assign in_ready = !q_valid[dest] || q_ack[dest];
`endif

   assign accept = in_valid && in_ready;

   always_comb begin
      load = '0;
      if (accept) load[dest] = 1'b1;
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
      demux_slot u_slot (
         .clk     (clk),
         .rst_n   (rst_n),
         .load    (load[k]),
         .ack     (q_ack[k]),
         .data    (data_in),
         .q       (q[k*WIDTH +: WIDTH]),
         .valid   (q_valid[k]),
         .overrun (overrun[k])
      );
   end

   // 4-bit pointer wraps 15 -> 0 naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (accept && auto_inc) begin
         ptr <= ptr + 4'd1;
      end
   end

   // Only one slot can load per cycle, so at most one overrun pulse is present.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_cnt <= '0;
      end else if ((|overrun) && (overrun_cnt != OVERRUN_MAX)) begin
         overrun_cnt <= overrun_cnt + 8'd1;
      end
   end

endmodule
